// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_pkg
//  Description : Shared constants and helpers for the pipelined Vedic
//                multiplier. Supplies the supported operand width range,
//                a constant-foldable ceil(log2) function and an elaboration
//                guard macro that rejects unsupported WIDTH values.
//  Contents    : MIN_WIDTH, MAX_WIDTH, clog2(), `VEDIC_CHECK_WIDTH(W)
//  Revision    : 1.0 - initial release
// ============================================================================
package vedic_pkg;

  localparam int MIN_WIDTH = 8;
  localparam int MAX_WIDTH = 64;

  // ceil(log2(value)); bounded loop so it folds cleanly at elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// A width is legal only if it is an exact power of two inside the supported
// range; anything else stops elaboration with a readable message.
`ifndef VEDIC_CHECK_WIDTH
`define VEDIC_CHECK_WIDTH(W) \
  if (((1 << vedic_pkg::clog2(W)) != (W)) || ((W) < vedic_pkg::MIN_WIDTH) || ((W) > vedic_pkg::MAX_WIDTH)) begin : g_bad_width \
    $error("vedic_mult_pipe: WIDTH must be a power of two between 8 and 64"); \
  end
`endif

`default_nettype wire

// File: rtl/vedic_core.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_core
//  Description : Combinational unsigned NxN Vedic (Urdhva-Tiryagbhyam)
//                multiplier. Recursively built from four N/2 cores whose
//                partial products are merged with adders; N = 2 is the
//                gate-level base case.
//  Ports       : i_a [N-1:0]   multiplicand
//                i_b [N-1:0]   multiplier
//                o_p [2N-1:0]  unsigned product
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_core
  import vedic_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  if (N == 2) begin : g_base
    logic w_x0;
    logic w_x1;
    logic w_hh;
    logic w_c1;

    // Vertical and crosswise 1-bit products of the 2x2 base multiplier.
    assign w_x0 = i_a[1] & i_b[0];
    assign w_x1 = i_a[0] & i_b[1];
    assign w_hh = i_a[1] & i_b[1];
    assign w_c1 = w_x0 & w_x1;

    assign o_p[0] = i_a[0] & i_b[0];
    assign o_p[1] = w_x0 ^ w_x1;
    assign o_p[2] = w_hh ^ w_c1;
    assign o_p[3] = w_hh & w_c1;
  end else begin : g_rec
    localparam int HN = N / 2;

    logic [N-1:0]   w_ll;
    logic [N-1:0]   w_hl;
    logic [N-1:0]   w_lh;
    logic [N-1:0]   w_hh;
    logic [N:0]     w_cross;

    vedic_core #(.N(HN)) u_ll (.i_a(i_a[HN-1:0]), .i_b(i_b[HN-1:0]), .o_p(w_ll));
    vedic_core #(.N(HN)) u_hl (.i_a(i_a[N-1:HN]), .i_b(i_b[HN-1:0]), .o_p(w_hl));
    vedic_core #(.N(HN)) u_lh (.i_a(i_a[HN-1:0]), .i_b(i_b[N-1:HN]), .o_p(w_lh));
    vedic_core #(.N(HN)) u_hh (.i_a(i_a[N-1:HN]), .i_b(i_b[N-1:HN]), .o_p(w_hh));

    // Cross terms get one extra bit so their carry survives the shift.
    assign w_cross = {1'b0, w_hl} + {1'b0, w_lh};

    assign o_p = {{N{1'b0}}, w_ll}
               + ({{(N-1){1'b0}}, w_cross} << HN)
               + {w_hh, {N{1'b0}}};
  end

endmodule

`default_nettype wire

// File: rtl/vedic_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_mult_pipe
//  Description : Three-stage pipelined WIDTH x WIDTH multiplier with
//                valid/ready handshake, per-transaction signed/unsigned
//                mode and a tag passthrough. The whole pipe advances as a
//                unit whenever the output is empty or being drained.
//                  S1: sign strip -> magnitudes, sign of result, tag
//                  S2: four (WIDTH/2)^2 Vedic partial products
//                  S3: partial-product merge and sign restore
//  Ports       : clk, rst_n             clock, async active-low reset
//                in_valid/in_ready      operand handshake
//                in_a, in_b, in_signed  operands and mode
//                in_tag                 sideband tag
//                out_valid/out_ready    product handshake
//                out_p, out_tag         product and its tag
//                out_busy               any stage holds a valid entry
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_busy
);

  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;

  `VEDIC_CHECK_WIDTH(WIDTH)

  // --------------------------------------------------------------------------
  // Flow control: a single advance enable for every stage.
  // --------------------------------------------------------------------------
  logic w_adv;
  logic w_accept;

  logic r_v1;
  logic r_v2;
  logic r_v3;

  assign w_adv    = !r_v3 | out_ready;
  assign w_accept = in_valid & w_adv;
  assign in_ready = w_adv;

  // --------------------------------------------------------------------------
  // Stage 1: magnitudes and result sign.
  // --------------------------------------------------------------------------
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic             r_neg1;
  logic [TAG_W-1:0] r_tag1;

  assign w_sign_a = in_signed & in_a[WIDTH-1];
  assign w_sign_b = in_signed & in_b[WIDTH-1];
  // The most negative value negates to itself, which is exactly its
  // unsigned magnitude, so WIDTH bits are sufficient.
  assign w_mag_a  = w_sign_a ? -in_a : in_a;
  assign w_mag_b  = w_sign_b ? -in_b : in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg1  <= 1'b0;
      r_tag1  <= '0;
    end else if (w_adv) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_mag_a <= w_mag_a;
        r_mag_b <= w_mag_b;
        r_neg1  <= w_sign_a ^ w_sign_b;
        r_tag1  <= in_tag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: four half-width partial products.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_ll;
  logic [WIDTH-1:0] w_hl;
  logic [WIDTH-1:0] w_lh;
  logic [WIDTH-1:0] w_hh;

  logic [WIDTH-1:0] r_ll;
  logic [WIDTH-1:0] r_hl;
  logic [WIDTH-1:0] r_lh;
  logic [WIDTH-1:0] r_hh;
  logic             r_neg2;
  logic [TAG_W-1:0] r_tag2;

  vedic_core #(.N(H)) u_core_ll (.i_a(r_mag_a[H-1:0]),     .i_b(r_mag_b[H-1:0]),     .o_p(w_ll));
  vedic_core #(.N(H)) u_core_hl (.i_a(r_mag_a[WIDTH-1:H]), .i_b(r_mag_b[H-1:0]),     .o_p(w_hl));
  vedic_core #(.N(H)) u_core_lh (.i_a(r_mag_a[H-1:0]),     .i_b(r_mag_b[WIDTH-1:H]), .o_p(w_lh));
  vedic_core #(.N(H)) u_core_hh (.i_a(r_mag_a[WIDTH-1:H]), .i_b(r_mag_b[WIDTH-1:H]), .o_p(w_hh));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_ll   <= '0;
      r_hl   <= '0;
      r_lh   <= '0;
      r_hh   <= '0;
      r_neg2 <= 1'b0;
      r_tag2 <= '0;
    end else if (w_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_ll   <= w_ll;
        r_hl   <= w_hl;
        r_lh   <= w_lh;
        r_hh   <= w_hh;
        r_neg2 <= r_neg1;
        r_tag2 <= r_tag1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: merge and restore sign.
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_cross;
  logic [PW-1:0]    w_mag;
  logic [PW-1:0]    w_prod;

  logic [PW-1:0]    r_p;
  logic [TAG_W-1:0] r_tag3;

  assign w_cross = {1'b0, r_hl} + {1'b0, r_lh};
  assign w_mag   = {{WIDTH{1'b0}}, r_ll}
                 + ({{(WIDTH-1){1'b0}}, w_cross} << H)
                 + {r_hh, {WIDTH{1'b0}}};
  // Negating a zero magnitude wraps back to zero, so a zero operand with a
  // set sign still yields 0.
  assign w_prod  = r_neg2 ? -w_mag : w_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3   <= 1'b0;
      r_p    <= '0;
      r_tag3 <= '0;
    end else if (w_adv) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_p    <= w_prod;
        r_tag3 <= r_tag2;
      end
    end
  end

  assign out_valid = r_v3;
  assign out_p     = r_p;
  assign out_tag   = r_tag3;
  assign out_busy  = r_v1 | r_v2 | r_v3;

endmodule

`default_nettype wire

// File: doc/vedic_mult_pipe.md
Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational Vedic multipliers.
- Accepts WIDTH x WIDTH operands through a valid/ready handshake.
- Supports unsigned or two's-complement signed mode per transaction, plus an optional tag passthrough.
- Produces a 2*WIDTH product after a fixed 3-cycle latency. Sits between datapath FIFOs and tolerates full backpressure.

Parameters:
- WIDTH, 16, operand width. Must be a power of two, 8..64; other values fail elaboration.
- TAG_W, 4, width of the sideband tag carried alongside each product.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands this cycle
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_signed  input  1  1 = treat in_a/in_b as two's complement; 0 = unsigned
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts product
- out_p  output  2*WIDTH  product
- out_tag  output  TAG_W  tag of the product
- out_busy  output  1  any pipeline stage holds a valid entry

Behaviour:
- Reset (async assert, sync-released by the integrator):
  - all stage valid bits = 0; out_valid = 0, out_busy = 0
  - out_p = 0, out_tag = 0
  - in_ready = 1 from the first cycle after release.
- Pipeline advance: adv = !out_valid | out_ready. Every stage register loads only when adv = 1; all stages hold otherwise. No bubbles are inserted or squashed beyond what the valid bits carry.
- in_ready = adv, purely combinational from out_valid/out_ready. No combinational path from in_valid to in_ready.
- Accept: handshake when in_valid & in_ready. Data is not sampled in any other cycle.
- Stage S1 (register after accept):
  - sign_a = in_signed & in_a[MSB]; sign_b likewise.
  - Store magnitudes |a| and |b| as WIDTH-bit unsigned values. 2^(WIDTH-1) is representable.
  - Store neg = sign_a ^ sign_b, the tag, and v1.
- Stage S2:
  - Split each magnitude into halves of H = WIDTH/2 bits.
  - Register four HxH partial products: ll, hl, lh, hh (each 2H bits) via vedic_core instances.
  - Carry neg, tag and v2.
- Stage S3:
  - mag = ll + ((hl + lh) << H) + (hh << WIDTH). Compute the cross-term sum at H*2+1 bits so no carry is lost. Total is 2*WIDTH bits; overflow is impossible.
  - out_p = neg ? (~mag + 1) : mag. Register into out_p/out_tag; out_valid = v3.
- Latency: an accepted operand appears on out_valid exactly 3 clk edges later if out_ready stays high.
- Throughput: one result per cycle. Results stay in order.
- Backpressure: while out_valid & !out_ready, out_p/out_tag/out_valid are held stable and the pipeline freezes. Up to 3 results are buffered in the stages.
- Simultaneous accept and drain in the same cycle is legal and keeps full throughput.
- Zero operand: mag = 0 and neg is irrelevant; out_p must be 0, never 2^(2*WIDTH).
- Reset mid-operation: all in-flight entries are discarded with no partial output. out_valid drops asynchronously with rst_n.
- out_busy = v1 | v2 | v3.

Decomposition:
- Package vedic_pkg:
  - localparam function clog2
  - typedef-free constants MIN_WIDTH = 8, MAX_WIDTH = 64
  - elaboration check macro for power-of-two WIDTH.
- Sub-module vedic_core (parameter N): combinational unsigned NxN Vedic multiplier.
  - Built recursively from four N/2 cores plus adders; the base case is N = 2.
  - Instantiated four times in S2 with N = H.

Test Plan (WIDTH=16, TAG_W=4):
- Unsigned corner: a=0xFFFF, b=0xFFFF, signed=0, tag=0x3 -> after 3 cycles out_p=0xFFFE0001, out_tag=0x3.
- Signed mixed/min: (a=0xFFFD, b=0x0005, signed=1) -> 0xFFFFFFF1. (a=0x8000, b=0x8000, signed=1) -> 0x40000000. (a=0x8000, b=0x0001, signed=1) -> 0xFFFF8000.
- Zero/sign: a=0x0000, b=0x8000, signed=1 -> out_p=0x00000000. a=0xFFFF, b=0xFFFF, signed=1 -> 0x00000001.
- Back-to-back throughput: 100 random pairs on consecutive cycles with out_ready=1 -> 100 results on 100 consecutive cycles starting at cycle 3. Results in order and matching the reference model; in_ready stays 1.
- Backpressure: fill, then hold out_ready=0 for 10 cycles -> out_p stable, in_ready=0 after 3 accepts, no loss or duplication. Release -> remaining results drain in order.
- Reset mid-stream: assert rst_n=0 with 3 entries in flight -> out_valid=0 and out_busy=0 immediately. After release, the first new operand (0x0002 x 0x0003) yields 0x00000006 with no stale output.
